// File: rtl/datapath_p.sv
// rtl/datapath_p.sv - four-state register-file datapath (IDLE/READ/EXEC/WB) with
// shifter, ALU, N/V/Z flags and an external register-file write port.
module datapath_p #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rs_a,
  input  logic [RW-1:0] rs_b,
  input  logic [1:0]    shift,
  input  logic          use_imm,
  input  logic [W-1:0]  imm,
  input  logic          set_flags,
  input  logic          ext_we,
  input  logic [RW-1:0] ext_waddr,
  input  logic [W-1:0]  ext_wdata,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [2:0]    flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_MVN = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [2:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d, rs_a_q, rs_a_d, rs_b_q, rs_b_d;
  logic [1:0]    shift_q, shift_d;
  logic          use_imm_q, use_imm_d, set_flags_q, set_flags_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]    flags_q, flags_d;
  logic [W-1:0]  rf_q [NREG];
  logic [W-1:0]  rf_d [NREG];

  logic [W-1:0]  b_reg, b_shifted, alu_res;
  logic          alu_v, alu_ok;

  always_comb begin
    b_reg = rf_q[rs_b_q];
    case (shift_q)
      2'b01:   b_shifted = {b_reg[W-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_reg[W-1:1]};
      2'b11:   b_shifted = {b_reg[W-1], b_reg[W-1:1]};
      default: b_shifted = b_reg;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_res = a_q + b_q;
        alu_v   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = a_q - b_q;
        alu_v   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_MVN:  alu_res = ~b_q;
      OP_MOV:  alu_res = b_q;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_a_d      = rs_a_q;
    rs_b_d      = rs_b_q;
    shift_d     = shift_q;
    use_imm_d   = use_imm_q;
    imm_d       = imm_q;
    set_flags_d = set_flags_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    flags_d     = flags_q;
    rf_d        = rf_q;
    // ext write first so a same-register write-back below overrides it
    if (ext_we) rf_d[ext_waddr] = ext_wdata;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d        = op;
          rd_d        = rd;
          rs_a_d      = rs_a;
          rs_b_d      = rs_b;
          shift_d     = shift;
          use_imm_d   = use_imm;
          imm_d       = imm;
          set_flags_d = set_flags;
          busy_d      = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        a_d     = rf_q[rs_a_q];
        b_d     = use_imm_q ? imm_q : b_shifted;
        state_d = EXEC;
      end
      EXEC: begin
        if (alu_ok) begin
          result_d = alu_res;
          if (set_flags_q || op_q == OP_CMP)
            flags_d = {(alu_res == '0), alu_v, alu_res[W-1]};
        end
        done_d  = 1'b1;
        state_d = WB;
      end
      default: begin
        if (op_q <= OP_MOV) rf_d[rd_q] = result_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      rs_a_q      <= '0;
      rs_b_q      <= '0;
      shift_q     <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      set_flags_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      rf_q        <= '{default: '0};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_a_q      <= rs_a_d;
      rs_b_q      <= rs_b_d;
      shift_q     <= shift_d;
      use_imm_q   <= use_imm_d;
      imm_q       <= imm_d;
      set_flags_q <= set_flags_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      rf_q        <= rf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule
